// File: rtl/sequential_detector_shift_register.sv
// ---------------------------------------------------------------------------
// sequential_detector_shift_register
//
// Purpose:
//   Serial pattern detector built on a shift register (no explicit FSM).
//   One bit of x is shifted in per rising clk edge. z flags whenever the most
//   recent PAT_LEN bits equal PATTERN (MSB = oldest bit, LSB = newest).
//   Overlapping matches are detected because the history is never cleared on
//   a match.
//
// Ports:
//   clk        in   1  rising-edge clock, the only clock
//   rst        in   1  synchronous, active-high reset
//   x          in   1  serial data bit, sampled on every rising clk edge
//   z          out  1  match flag, high while history == PATTERN and full
//   match_cnt  out  8  wrapping count of matches (only with SEQDET_MATCH_CNT_EN)
//
// Configuration macro:
//   SEQDET_MATCH_CNT_EN  adds the match_cnt output and its 8-bit counter.
//                        z behaves identically with or without it.
//
// Handshake: none. x is a free-running serial stream with no valid/ready
//   qualification; every non-reset edge consumes exactly one bit.
// ---------------------------------------------------------------------------
module sequential_detector_shift_register #(
  parameter int unsigned         PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0]  PATTERN = 5'b10010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  output logic       z
`ifdef SEQDET_MATCH_CNT_EN
  ,
  output logic [7:0] match_cnt
`endif
);

  // Fill counter must be able to hold the value PAT_LEN itself.
  localparam int unsigned      FW        = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] sr_q, sr_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               full;

  assign full = (fill_q == FILL_FULL);

  always_comb begin
    sr_d   = {sr_q[PAT_LEN-2:0], x};
    // Saturate at PAT_LEN: once the history is full it stays full.
    fill_d = full ? fill_q : (fill_q + FW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else begin
      sr_q   <= sr_d;
      fill_q <= fill_d;
    end
  end

  // Decoded from registers only, so x has no combinational path to z.
  // The fill guard keeps an all-zero PATTERN from matching the cleared
  // register straight out of reset.
  assign z = full && (sr_q == PATTERN);

`ifdef SEQDET_MATCH_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Counts on the edge after z was high; wraps naturally from 255 to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (z) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sequential_detector_shift_register.sv
// ---------------------------------------------------------------------------
// tb_sequential_detector_shift_register
//
// Directed bench for sequential_detector_shift_register (PAT_LEN=5,
// PATTERN=10010). Inputs change 1 time unit after a rising edge; outputs are
// checked 1 time unit after the edge that samples each bit.
// ---------------------------------------------------------------------------
module tb_sequential_detector_shift_register;

  logic       clk;
  logic       rst;
  logic       x;
  logic       z;
`ifdef SEQDET_MATCH_CNT_EN
  logic [7:0] match_cnt;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [0:0] exp_q[$];

  sequential_detector_shift_register dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .z         (z)
`ifdef SEQDET_MATCH_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  // One edge with rst held high; x is driven to 1 to show it is discarded.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b1;
      x   = 1'b1;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    rst = 1'b0;
    x   = b;
    @(posedge clk);
    #1;
  endtask

  // Shift one bit and check z against a hand-computed value.
  task automatic shift_chk(input logic b, input logic exp_z, input string tag);
    shift_bit(b);
    check(tag, {31'd0, z}, {31'd0, exp_z});
  endtask

  // ---------------- reference model for near-miss sweep ----------------
  logic [4:0] ref_hist;
  int         ref_fill;

  task automatic ref_clear();
    ref_hist = '0;
    ref_fill = 0;
  endtask

  task automatic ref_push(input logic b);
    ref_hist = {ref_hist[3:0], b};
    if (ref_fill < 5) ref_fill++;
    exp_q.push_back((ref_fill == 5 && ref_hist == 5'b10010) ? 1'b1 : 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [23:0] rot_stream;
  logic [14:0] near_miss;

  initial begin
    rst = 1'b1;
    x   = 1'b0;
    ref_clear();

    // 1: reset held two edges with x=1, then partial pattern 1,0,0,1.
    do_reset(2);
    check("reset_z", {31'd0, z}, 32'd0);
`ifdef SEQDET_MATCH_CNT_EN
    check("reset_cnt", {24'd0, match_cnt}, 32'd0);
`endif
    shift_chk(1'b1, 1'b0, "t1_b0");
    shift_chk(1'b0, 1'b0, "t1_b1");
    shift_chk(1'b0, 1'b0, "t1_b2");
    shift_chk(1'b1, 1'b0, "t1_b3");

    // 2: single match after a fresh reset, then next x=1 drops z.
    do_reset(1);
    shift_chk(1'b1, 1'b0, "t2_b0");
    shift_chk(1'b0, 1'b0, "t2_b1");
    shift_chk(1'b0, 1'b0, "t2_b2");
    shift_chk(1'b1, 1'b0, "t2_b3");
    shift_chk(1'b0, 1'b1, "t2_match");
    shift_chk(1'b1, 1'b0, "t2_after");
    // History now ...1,0,0,1,0,1; 0,0,1,0 completes 10010 again.
    shift_chk(1'b0, 1'b0, "t2_c0");
    shift_chk(1'b0, 1'b0, "t2_c1");
    shift_chk(1'b1, 1'b0, "t2_c2");
    shift_chk(1'b0, 1'b1, "t2_rematch");
    // Reset while z is high clears it right after that edge.
    do_reset(1);
    check("t2_rst_clears_z", {31'd0, z}, 32'd0);

    // 3: overlap 1,0,0,1,0,0,1,0 -> pulses after bits 5 and 8.
    do_reset(1);
    shift_chk(1'b1, 1'b0, "t3_b0");
    shift_chk(1'b0, 1'b0, "t3_b1");
    shift_chk(1'b0, 1'b0, "t3_b2");
    shift_chk(1'b1, 1'b0, "t3_b3");
    shift_chk(1'b0, 1'b1, "t3_b4");
    shift_chk(1'b0, 1'b0, "t3_b5");
    shift_chk(1'b1, 1'b0, "t3_b6");
    shift_chk(1'b0, 1'b1, "t3_b7");
    shift_chk(1'b0, 1'b0, "t3_b8");
`ifdef SEQDET_MATCH_CNT_EN
    // Second pulse is counted on the edge following it.
    check("t3_cnt", {24'd0, match_cnt}, 32'd2);
`endif

    // 4: rotating 24-bit stream, pulses at stream bits 9, 12, 20.
    rot_stream = 24'b0000_1100_1001_0000_1001_0100;
    do_reset(1);
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 24; i++) begin
        logic ez;
        ez = (i == 9 || i == 12 || i == 20);
        shift_chk(rot_stream[23-i], ez, $sformatf("t4_r%0d_b%0d", rep, i));
      end
    end
`ifdef SEQDET_MATCH_CNT_EN
    check("t4_cnt", {24'd0, match_cnt}, 32'd9);
`endif

    // 5: reset mid-pattern loses history.
    do_reset(1);
    shift_chk(1'b1, 1'b0, "t5_p0");
    shift_chk(1'b0, 1'b0, "t5_p1");
    shift_chk(1'b0, 1'b0, "t5_p2");
    do_reset(1);
    check("t5_rst_z", {31'd0, z}, 32'd0);
    shift_chk(1'b1, 1'b0, "t5_q0");
    shift_chk(1'b0, 1'b0, "t5_q1");
    shift_chk(1'b0, 1'b0, "t5_q2");
    shift_chk(1'b1, 1'b0, "t5_q3");
    shift_chk(1'b0, 1'b1, "t5_q4");

    // 6: near-misses 10011, 00010, 11010 against the reference model.
    near_miss = 15'b10011_00010_11010;
    do_reset(1);
    ref_clear();
    for (int i = 14; i >= 0; i--) begin
      logic [0:0] e;
      ref_push(near_miss[i]);
      shift_bit(near_miss[i]);
      e = exp_q.pop_front();
      check($sformatf("t6_b%0d", 14 - i), {31'd0, z}, {31'd0, e});
    end

`ifdef SEQDET_MATCH_CNT_EN
    // 7: counter wrap. Stream 1,0 then (0,1,0) x N gives N-1 counted
    // pulses after the last triple, so N=256 -> 255 and N=257 -> 0.
    do_reset(1);
    shift_bit(1'b1);
    shift_bit(1'b0);
    for (int n = 1; n <= 257; n++) begin
      shift_bit(1'b0);
      shift_bit(1'b1);
      shift_bit(1'b0);
      if (n == 256) check("t7_cnt_255", {24'd0, match_cnt}, 32'd255);
      if (n == 257) check("t7_cnt_wrap", {24'd0, match_cnt}, 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
